// File: rtl/pc_unit.sv
// Program-counter unit at the head of IF: fetch-address register with valid/ready handshake,
// stall hold, prioritised trap/redirect, one-entry pending-target buffer and misalignment flag.
module pc_unit #(
  parameter int                XLEN          = 32,
  parameter logic [XLEN-1:0]   BASE_LOCATION = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VECTOR   = 32'h0000_0004,
  parameter int                INC_BYTES     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC_BYTES - 1);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_tgt_q;
  logic            pc_valid_q;
  logic            misalign_q;

  logic            upd;
  logic            tgt_misaligned;
  logic [XLEN-1:0] pend_next;

  // Handshake: a request is offered while pc_valid_o=1 and taken on an edge where
  // fetch_ready_i=1; an offered address never changes until it has been taken.
  assign upd            = ~pc_valid_q | fetch_ready_i;
  assign tgt_misaligned = |(redirect_target_i & ALIGN_MASK);
  // A trap arriving while a target is buffered replaces it.
  assign pend_next      = trap_i ? TRAP_VECTOR : pend_tgt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= BASE_LOCATION;
      pend_tgt_q <= '0;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (trap_i) begin
            if (upd) begin
              pc_q <= TRAP_VECTOR;
            end else begin
              pend_tgt_q <= TRAP_VECTOR;
              state_q    <= PEND;
            end
          end else if (redirect_valid_i) begin
            if (tgt_misaligned) begin
              misalign_q <= 1'b1;
            end else if (upd) begin
              pc_q <= redirect_target_i;
            end else begin
              pend_tgt_q <= redirect_target_i;
              state_q    <= PEND;
            end
          end else if (!stall_i && fetch_ready_i) begin
            pc_q <= pc_q + INC_VAL;
          end
        end
        PEND: begin
          // Redirects here come from the wrong path and stall has no say.
          if (fetch_ready_i) begin
            pc_q    <= pend_next;
            state_q <= RUN;
          end else begin
            pend_tgt_q <= pend_next;
          end
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = pc_valid_q;
  assign pc_plus_o  = pc_q + INC_VAL;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed test-plan steps followed by random traffic, all checked
// against a behavioural model of the fetch-address sequence.
module tb_pc_unit;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] TRAP = 32'h0000_0004;
  localparam int unsigned INC  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        fetch_ready_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic        trap_i = 1'b0;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic [31:0] pc_plus_o;
  logic        misalign_o;

  pc_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .fetch_ready_i     (fetch_ready_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .trap_i            (trap_i),
    .pc_o              (pc_o),
    .pc_valid_o        (pc_valid_o),
    .pc_plus_o         (pc_plus_o),
    .misalign_o        (misalign_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_has_pend;
  logic [31:0] m_pend_tgt;
  bit          m_mis;

  // Scoreboard: fetch addresses the model expects instruction memory to accept.
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];

  int n_total = 0;
  int n_pass  = 0;

  always @(posedge clk) begin
    if (!rst && pc_valid_o && fetch_ready_i) act_q.push_back(pc_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc       = BASE;
    m_valid    = 0;
    m_has_pend = 0;
    m_pend_tgt = '0;
    m_mis      = 0;
    exp_q.delete();
    act_q.delete();
  endtask

  // What the next edge does, phrased as the rules of the unit rather than its registers.
  task automatic model_edge(input bit st, input bit rdy, input bit rv,
                            input logic [31:0] tgt, input bit tr);
    m_mis = 0;
    if (!m_valid) begin
      m_valid = 1;
    end else if (m_has_pend) begin
      if (tr) m_pend_tgt = TRAP;
      if (rdy) begin
        m_pc       = m_pend_tgt;
        m_has_pend = 0;
      end
    end else if (tr || (rv && (tgt % INC) == 0)) begin
      logic [31:0] dest;
      dest = tr ? TRAP : tgt;
      if (rdy) m_pc = dest;
      else begin
        m_pend_tgt = dest;
        m_has_pend = 1;
      end
    end else if (rv) begin
      m_mis = 1;
    end else if (!st && rdy) begin
      m_pc = 32'((64'(m_pc) + INC) % 64'h1_0000_0000);
    end
  endtask

  task automatic compare_outputs();
    chk("pc_o", pc_o, m_pc);
    chk("pc_valid_o", {31'd0, pc_valid_o}, {31'd0, m_valid});
    chk("misalign_o", {31'd0, misalign_o}, {31'd0, m_mis});
    while (exp_q.size() > 0 && act_q.size() > 0)
      chk("accepted_addr", act_q.pop_front(), exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit st, input bit rdy, input bit rv,
                       input logic [31:0] tgt, input bit tr);
    stall_i           = st;
    fetch_ready_i     = rdy;
    redirect_valid_i  = rv;
    redirect_target_i = tgt;
    trap_i            = tr;
    #1;
    chk("pc_plus_o", pc_plus_o, 32'((64'(m_pc) + INC) % 64'h1_0000_0000));
    if (m_valid && rdy) exp_q.push_back(m_pc);
    model_edge(st, rdy, rv, tgt, tr);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pc_o", pc_o, BASE);
    chk("rst_pc_valid_o", {31'd0, pc_valid_o}, 32'd0);
    chk("rst_misalign_o", {31'd0, misalign_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // Boot and sequential fetch
    cycle(0, 1, 0, '0, 0);
    chk("boot_pc", pc_o, 32'h0);
    chk("boot_valid", {31'd0, pc_valid_o}, 32'd1);
    run(3);
    chk("seq_pc_c", pc_o, 32'hC);
    run(1);

    // Stall then backpressure
    repeat (3) cycle(1, 1, 0, '0, 0);
    chk("stall_hold", pc_o, 32'h10);
    run(1);
    chk("stall_resume", pc_o, 32'h14);
    repeat (2) cycle(0, 0, 0, '0, 0);
    chk("bp_hold", pc_o, 32'h14);

    // Redirect under backpressure; later redirect while pending is ignored
    cycle(0, 1, 1, 32'h20, 0);
    cycle(0, 0, 1, 32'h100, 0);
    chk("pend_hold", pc_o, 32'h20);
    cycle(1, 0, 1, 32'h200, 0);
    chk("pend_ignore", pc_o, 32'h20);
    cycle(0, 1, 0, '0, 0);
    chk("pend_apply", pc_o, 32'h100);
    run(1);
    chk("pend_back_run", pc_o, 32'h104);

    // Trap priority
    cycle(0, 1, 1, 32'h80, 1);
    chk("trap_over_redirect", pc_o, TRAP);
    cycle(0, 0, 1, 32'h100, 0);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 1, 0, '0, 0);
    chk("trap_in_pend", pc_o, TRAP);

    // Misaligned redirect
    cycle(0, 1, 1, 32'h40, 0);
    cycle(0, 1, 1, 32'h102, 0);
    chk("mis_hold", pc_o, 32'h40);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    run(1);
    chk("mis_resume", pc_o, 32'h44);
    chk("mis_clear", {31'd0, misalign_o}, 32'd0);

    // Wrap
    cycle(0, 1, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_plus", pc_plus_o, 32'h0);
    run(1);
    chk("wrap_pc", pc_o, 32'h0);

    // Reset while a target is pending discards it
    run(2);
    cycle(0, 0, 1, 32'h300, 0);
    do_reset();
    cycle(0, 1, 0, '0, 0);
    run(1);
    chk("rst_discard_pend", pc_o, 32'h4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit st, rdy, rv, tr;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 4) == 0);
      tr  = ($urandom_range(0, 15) == 0);
      tgt = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) tgt = tgt & ~32'h3;
      if (i == 300) begin
        do_reset();
      end
      cycle(st, rdy, rv, tgt, tr);
    end

    chk("scoreboard_drained", exp_q.size(), act_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined core. It generalises the plain PC register with several additions:
- a valid/ready fetch handshake toward instruction memory;
- stall hold;
- prioritised redirect and trap inputs;
- a one-entry pending-redirect buffer;
- misaligned-target detection.

It sits at the head of the IF stage. It drives the fetch address and the PC+increment value passed down the pipeline.

## Interface
- XLEN, 32, address/PC width
- BASE_LOCATION, 32'h00000000, PC value loaded at reset
- TRAP_VECTOR, 32'h00000004, PC value loaded on trap
- INC_BYTES, 4, sequential increment (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  hazard hold from decode; blocks sequential advance only
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle
- redirect_valid_i  in  1  branch/jump taken, from EX
- redirect_target_i  in  XLEN  redirect destination
- trap_i  in  1  exception/interrupt request, 1-cycle pulse
- pc_o  out  XLEN  current fetch address
- pc_valid_o  out  1  fetch request valid
- pc_plus_o  out  XLEN  pc_o + INC_BYTES, modulo 2^XLEN, combinational
- misalign_o  out  1  registered 1-cycle flag: redirect target was misaligned

## Operation
- **Stability rule:** while pc_valid_o=1 and fetch_ready_i=0, pc_o must not change. An outstanding request is held until accepted.
- **Update permission:** upd = ~pc_valid_o | fetch_ready_i.
- **States:**
  - BOOT, entered on reset: pc_valid_o=0. BOOT→RUN at the next edge, unconditionally.
  - RUN: normal operation.
  - PEND: one target is buffered.
- **Next-PC priority, evaluated in RUN (highest first):**
  - trap_i: if upd, pc←TRAP_VECTOR; else pend_tgt←TRAP_VECTOR and go to PEND.
  - redirect_valid_i with aligned target: if upd, pc←target; else pend_tgt←target and go to PEND.
  - redirect_valid_i with misaligned target: PC unchanged, nothing buffered, misalign_o=1 next cycle.
  - stall_i: hold.
  - fetch_ready_i: pc←pc+INC_BYTES.
  - otherwise: hold.
- **Misaligned target:** target[log2(INC_BYTES)-1:0] != 0.
- **PEND state:**
  - trap_i overwrites pend_tgt with TRAP_VECTOR.
  - redirect_valid_i is ignored; it comes from a wrong-path instruction.
  - stall_i is ignored.
  - When fetch_ready_i=1: pc←pend_tgt and go to RUN.
- **Redirect and trap override stall**, subject only to the stability rule.
- pc_valid_o=1 in RUN and PEND. The wrong-path request issued in PEND completes normally; flushing it is downstream's job.

## Timing
- **Reset values:** pc_o=BASE_LOCATION, pc_valid_o=0, misalign_o=0, state=BOOT, pend_tgt=0.
- Reset asserted mid-PEND discards the buffered target.
- **First request:** pc_valid_o rises one edge after rst deasserts, with pc_o=BASE_LOCATION.
- **Redirect/trap latency:**
  - With upd=1: 1 cycle, so the new pc_o is visible after the next edge.
  - From PEND: applied at the first edge with fetch_ready_i=1.
- misalign_o is high exactly one cycle, the cycle after the offending redirect.
- pc_plus_o is zero-latency and wraps: 0xFFFFFFFC+4 → 0x00000000.

## Test plan
- **Reset/boot:** rst high, pulsed mid-run -> pc_o immediately 0x00000000 and pc_valid_o=0. One cycle after release pc_valid_o=1, pc_o=0x0. With ready=1, pc_o steps 0x4, 0x8, 0xC.
- **Stall and backpressure:**
  - At pc=0x10, stall_i=1 for 3 cycles -> pc_o holds 0x10, then resumes at 0x14.
  - With fetch_ready_i=0 and stall_i=0 -> pc_o holds.
- **Redirect under backpressure:**
  - At pc=0x20 with ready=0, redirect to 0x100 -> pc_o stays 0x20.
  - A later redirect to 0x200 while pending is ignored.
  - On ready=1 -> pc_o=0x100 next cycle, state RUN.
- **Trap priority:**
  - Same cycle trap_i and redirect to 0x80 -> pc_o=0x4.
  - Trap while PEND(0x100) -> pc_o=0x4 when ready rises.
- **Misaligned redirect:** at pc=0x40, redirect to 0x102 -> pc_o holds 0x40, misalign_o=1 for exactly 1 cycle, then sequential fetch continues at 0x44.
- **Wrap:** pc=0xFFFFFFFC -> pc_plus_o=0x0; advancing gives pc_o=0x0.
